// File: rtl/serial_div_const.sv
// Bit-serial restoring division of a WIDTH-bit word by a constant divisor.
// Words can be chained MSW-first by feeding one word's Yout into the next word's Yin.
module serial_div_const #(
  parameter  int unsigned WIDTH   = 4,
  parameter  int unsigned DIVISOR = 3,
  localparam int unsigned RW      = $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [RW-1:0]    Yin,
  input  logic             chain,
  output logic [WIDTH-1:0] Z,
  output logic [RW-1:0]    Yout,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned     CW       = $clog2(WIDTH);
  localparam logic [RW:0]     DIV_T    = (RW+1)'(DIVISOR);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH-1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [RW-1:0]    rem_q;
  logic [CW-1:0]    cnt_q;
  logic             err_pend_q;
  logic [WIDTH-1:0] z_q;
  logic [RW-1:0]    yout_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic             qbit_d;
  logic [RW-1:0]    rem_d;
  logic [WIDTH-1:0] sh_d;
  logic             yin_bad;

  // One restoring step: returns {quotient bit, next remainder}.
  function automatic logic [RW:0] div_step(input logic [RW-1:0] rem, input logic bit_in);
    logic [RW:0] t;
    t = {rem, bit_in};
    if (t >= DIV_T) div_step = {1'b1, RW'(t - DIV_T)};
    else            div_step = {1'b0, t[RW-1:0]};
  endfunction

  always_comb begin
    {qbit_d, rem_d} = div_step(rem_q, sh_q[WIDTH-1]);
    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    sh_d    = {sh_q[WIDTH-2:0], qbit_d};
    yin_bad = ({1'b0, Yin} >= DIV_T);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sh_q       <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
      z_q        <= '0;
      yout_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sh_q       <= X;
            rem_q      <= (chain && !yin_bad) ? Yin : '0;
            err_pend_q <= chain && yin_bad;
            cnt_q      <= CNT_LAST;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          sh_q  <= sh_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            z_q     <= sh_d;
            yout_q  <= rem_d;
            err_q   <= err_pend_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Z    = z_q;
  assign Yout = yout_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_serial_div_const.sv
// Randomised and directed bench for serial_div_const against an arithmetic
// reference (R0*2^W + X divided by D), using a 4/3 and an 8/7 instance.
module tb_serial_div_const;

  localparam int WA = 4;
  localparam int DA = 3;
  localparam int RA = 2;
  localparam int WB = 8;
  localparam int DB = 7;
  localparam int RB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic          start_a, chain_a, busy_a, done_a, err_a;
  logic [WA-1:0] x_a, z_a;
  logic [RA-1:0] yin_a, yout_a;

  logic          start_b, chain_b, busy_b, done_b, err_b;
  logic [WB-1:0] x_b, z_b;
  logic [RB-1:0] yin_b, yout_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  serial_div_const #(.WIDTH(WA), .DIVISOR(DA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .X(x_a), .Yin(yin_a), .chain(chain_a),
    .Z(z_a), .Yout(yout_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  serial_div_const #(.WIDTH(WB), .DIVISOR(DB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .X(x_b), .Yin(yin_b), .chain(chain_b),
    .Z(z_b), .Yout(yout_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  task automatic check_eq(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void ref_div(input int w, input int d, input int x, input int yin,
                                  input bit chain, output longint unsigned z,
                                  output longint unsigned y, output bit e);
    longint unsigned r0, num;
    e   = chain && (yin >= d);
    r0  = (chain && yin < d) ? longint'(yin) : 0;
    num = (r0 << w) + longint'(x);
    z   = num / d;
    y   = num % d;
  endfunction

  task automatic launch_a(input int x, input int yin, input bit chain);
    @(negedge clk);
    start_a = 1'b1;
    x_a     = WA'(x);
    yin_a   = RA'(yin);
    chain_a = chain;
    @(negedge clk);
  endtask

  // Entered at the first RUN cycle; checks timing, then the result.
  task automatic collect_a(input string tag, input int x, input int yin, input bit chain);
    longint unsigned ez, ey;
    bit ee;
    int busy_n = 0;
    int both = 0;
    bit seen = 0;
    start_a = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (busy_a && done_a) both++;
      if (done_a) seen = 1;
      else begin
        if (busy_a) busy_n++;
        @(negedge clk);
      end
    end
    ref_div(WA, DA, x, yin, chain, ez, ey, ee);
    check_eq($sformatf("%s done_seen", tag), seen, 1);
    check_eq($sformatf("%s busy_cycles", tag), busy_n, WA);
    check_eq($sformatf("%s busy_done_overlap", tag), both, 0);
    check_eq($sformatf("%s Z x=%0d yin=%0d ch=%0d", tag, x, yin, chain), z_a, ez);
    check_eq($sformatf("%s Yout x=%0d yin=%0d ch=%0d", tag, x, yin, chain), yout_a, ey);
    check_eq($sformatf("%s err x=%0d yin=%0d ch=%0d", tag, x, yin, chain), err_a, ee);
    @(negedge clk);
    check_eq($sformatf("%s done_one_cycle", tag), done_a, 0);
  endtask

  task automatic run_a(input string tag, input int x, input int yin, input bit chain);
    launch_a(x, yin, chain);
    collect_a(tag, x, yin, chain);
  endtask

  task automatic run_b(input string tag, input int x, input int yin, input bit chain);
    longint unsigned ez, ey;
    bit ee;
    bit seen = 0;
    @(negedge clk);
    start_b = 1'b1;
    x_b     = WB'(x);
    yin_b   = RB'(yin);
    chain_b = chain;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done_b) seen = 1;
      else @(negedge clk);
    end
    ref_div(WB, DB, x, yin, chain, ez, ey, ee);
    check_eq($sformatf("%s done_seen", tag), seen, 1);
    check_eq($sformatf("%s Z x=%0d yin=%0d ch=%0d", tag, x, yin, chain), z_b, ez);
    check_eq($sformatf("%s Yout x=%0d yin=%0d ch=%0d", tag, x, yin, chain), yout_b, ey);
    check_eq($sformatf("%s err x=%0d yin=%0d ch=%0d", tag, x, yin, chain), err_b, ee);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, zc, yc;
    int t_done[$];

    rst_n = 1'b0;
    start_a = 1'b0; x_a = '0; yin_a = '0; chain_a = 1'b0;
    start_b = 1'b0; x_b = '0; yin_b = '0; chain_b = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst Z", z_a, 0);
    check_eq("rst Yout", yout_a, 0);
    check_eq("rst busy", busy_a, 0);
    check_eq("rst done", done_a, 0);
    check_eq("rst err", err_a, 0);
    rst_n = 1'b1;

    // Directed cases
    run_a("x13", 13, 0, 0);
    check_eq("x13 Z const", z_a, 4);
    check_eq("x13 Yout const", yout_a, 1);
    run_a("x5y2", 5, 2, 1);
    check_eq("x5y2 Z const", z_a, 12);
    run_a("x6y3", 6, 3, 1);
    check_eq("x6y3 err const", err_a, 1);
    check_eq("x6y3 Z const", z_a, 2);
    run_a("x6nc", 6, 0, 0);
    check_eq("x6nc err const", err_a, 0);

    // start pulsed during the second RUN cycle must be ignored
    launch_a(9, 0, 0);
    start_a = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    x_a = 4'd2;
    @(negedge clk);
    start_a = 1'b0;
    ndone = 0; zc = 0; yc = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_a) begin
        ndone++;
        zc = int'(z_a);
        yc = int'(yout_a);
      end
      @(negedge clk);
    end
    check_eq("ignore_start done_count", ndone, 1);
    check_eq("ignore_start Z", zc, 3);
    check_eq("ignore_start Yout", yc, 0);

    // Continuous start: back-to-back every WIDTH+2 cycles
    @(negedge clk);
    start_a = 1'b1; x_a = 4'd13; chain_a = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (done_a) begin
        t_done.push_back(cyc);
        check_eq("b2b Z", z_a, 4);
      end
    end
    start_a = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("b2b count_ge3", t_done.size() >= 3, 1);
    for (int i = 1; i < t_done.size(); i++)
      check_eq($sformatf("b2b period %0d", i), t_done[i] - t_done[i-1], WA + 2);

    // Reset in the third RUN cycle of X=15 (previous Z is non-zero)
    launch_a(15, 0, 0);
    start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst Z", z_a, 0);
    check_eq("midrst Yout", yout_a, 0);
    check_eq("midrst busy", busy_a, 0);
    check_eq("midrst done", done_a, 0);
    check_eq("midrst err", err_a, 0);
    start_a = 1'b1;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_a || busy_a) ndone++;
    end
    check_eq("inreset no_activity", ndone, 0);
    rst_n = 1'b1;
    @(negedge clk);
    collect_a("after_rst", 15, 0, 0);
    check_eq("after_rst Z const", z_a, 5);

    // Exhaustive chained sweep on both instances
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 3; y++) begin
        run_a("exhA", x, y, 1);
        run_b("exhB", x, y, 1);
      end

    // Randomised operations, including invalid Yin
    for (int i = 0; i < 40; i++) begin
      run_a("rndA", int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      run_b("rndB", int'($urandom_range(0, 255)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_div_const.md
SERIAL_DIV_CONST -- requirements
Module: serial_div_const

Interface
REQ-001 SHALL have parameter WIDTH, default 4: dividend/quotient width in bits, legal range 2..32.
REQ-002 SHALL have parameter DIVISOR, default 3: constant divisor, legal range 2..15.
REQ-003 SHALL have derived localparam RW = clog2(DIVISOR): remainder width (2 for DIVISOR=3).
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1: request a new division; sampled only in IDLE.
REQ-007 SHALL have port X, input, WIDTH: dividend word; sampled with start.
REQ-008 SHALL have port Yin, input, RW: incoming remainder from the more-significant word; sampled with start.
REQ-009 SHALL have port chain, input, 1: 1 = use Yin as initial remainder, 0 = initial remainder 0; sampled with start.
REQ-010 SHALL have port Z, output, WIDTH: quotient, registered.
REQ-011 SHALL have port Yout, output, RW: final remainder, registered.
REQ-012 SHALL have port busy, output, 1: high while a division is in progress.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when Z/Yout become valid.
REQ-014 SHALL have port err, output, 1: invalid Yin flag for the current result.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE: on start=1 at a rising edge SHALL load shift register <- X, remainder <- (chain ? Yin : 0), bit counter <- WIDTH-1, go to RUN.
REQ-017 RUN: each edge SHALL form t = {remainder, shift MSB}; if t >= DIVISOR then quotient bit 1 and remainder <- t-DIVISOR, else quotient bit 0 and remainder <- t; shift left one bit.
REQ-018 RUN SHALL last exactly WIDTH cycles (MSB first); on the last RUN edge Z and Yout SHALL be updated and state SHALL go to DONE.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 Latency: start sampled at edge 0 -> Z/Yout valid and done=1 after edge WIDTH, i.e. WIDTH+1 cycles from start to done deasserting.
REQ-021 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; busy and done SHALL never be high together.
REQ-022 Z, Yout, err SHALL hold their values from DONE until the next DONE or reset.
REQ-023 start while in RUN or DONE SHALL be ignored and SHALL not be queued.
REQ-024 start asserted continuously SHALL launch a new division on the first IDLE edge, giving back-to-back operations every WIDTH+2 cycles.
REQ-025 If chain=1 and Yin >= DIVISOR, the initial remainder SHALL be 0 and err SHALL be 1 with that result; otherwise err SHALL be 0 with the result.
REQ-026 Result SHALL satisfy (R0*2^WIDTH + X) = Z*DIVISOR + Yout with Yout < DIVISOR, where R0 is the initial remainder.
REQ-027 Intermediate t SHALL be RW+1 bits wide; quotient SHALL not overflow WIDTH bits because R0 < DIVISOR.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state IDLE, Z=0, Yout=0, busy=0, done=0, err=0, and clear the shift register, remainder and counter.
REQ-029 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL behave as a fresh operation.
REQ-030 start SHALL be ignored on the edge coinciding with rst_n deassertion if rst_n was low at that edge.

Verification (WIDTH=4, DIVISOR=3 unless stated)
REQ-031 X=13, chain=0, start pulse -> busy 4 cycles, then done=1 for 1 cycle with Z=4, Yout=1, err=0.
REQ-032 X=5, Yin=2, chain=1 -> Z=12, Yout=1 (37 = 12*3+1), err=0.
REQ-033 X=6, Yin=3, chain=1 -> err=1, Z=2, Yout=0; next X=6, chain=0 -> err=0.
REQ-034 start pulsed in the second RUN cycle of X=9 -> ignored; single done with Z=3, Yout=0.
REQ-035 rst_n low in the third RUN cycle of X=15 -> outputs 0 immediately, no done; after release, X=15 -> Z=5, Yout=0.
REQ-036 Exhaustive: all X in 0..15 x all Yin in 0..2, chain=1, with WIDTH=4/DIVISOR=3 and WIDTH=8/DIVISOR=7 -> every result matches REQ-026.
